// File: rtl/adder_pkg.sv
// adder_pkg: shared nibble width, FSM states and index-width helper for the serial adder
package adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction
endpackage

// File: rtl/nibble_serial_adder_rca.sv
// RCA: 4-bit ripple-carry adder exposing every stage's carry-out
module RCA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic [3:0] carry
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    assign carry[i] = c[i+1];
  end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-word adder, one nibble per clock through a single RCA
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIBBLE_W*WORDS-1:0] a,
  input  logic [NIBBLE_W*WORDS-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIBBLE_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    overflow
);
  localparam int W  = NIBBLE_W * WORDS;
  localparam int IW = idx_w(WORDS);
  state_t state, next;
  logic [IW-1:0] idx;
  logic [W-1:0] sa, sb;
  logic c, last;
  logic [NIBBLE_W-1:0] rs, rc;
  RCA u_rca (
    .a    (sa[NIBBLE_W-1:0]),
    .b    (sb[NIBBLE_W-1:0]),
    .cin  (c),
    .sum  (rs),
    .carry(rc)
  );
  assign in_ready = state == IDLE && !rst;
  assign last     = idx == IW'(WORDS - 1);
  always_comb begin
    next = state;
    if (state == IDLE) next = in_valid ? RUN : IDLE;
    else if (state == RUN) next = last ? DONE : RUN;
    else next = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      c         <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE) begin
        if (in_valid) begin
          sa  <= a;
          sb  <= b;
          c   <= cin;
          idx <= '0;
        end
      end else if (state == RUN) begin
        sum[NIBBLE_W*idx +: NIBBLE_W] <= rs;
        c   <= rc[NIBBLE_W-1];
        sa  <= sa >> NIBBLE_W;
        sb  <= sb >> NIBBLE_W;
        idx <= idx + 1'b1;
        if (last) begin
          cout      <= rc[NIBBLE_W-1];
          overflow  <= rc[NIBBLE_W-2] ^ rc[NIBBLE_W-1];
          out_valid <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and randomized checks against an arithmetic reference model
module tb_nibble_serial_adder;
  localparam int WORDS = 4;
  localparam int W = 4 * WORDS;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, cin = 1'b0;
  logic out_valid, out_ready = 1'b1, cout, overflow;
  logic [W-1:0] a = '0, b = '0, sum;
  int n_checks = 0, n_fail = 0;

  nibble_serial_adder #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    logic ov;
    t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {ov, t};
  endfunction

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        output logic [W-1:0] s, output logic co, output logic ov, output int lat);
    int t;
    @(negedge clk);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin n_checks++; n_fail++; $display("FAIL accept_timeout: in_ready stayed 0"); end
    @(posedge clk);
    #1 in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    s = sum; co = cout; ov = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, cout, overflow, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b co=%b ovf=%b sum=%h, need all 0", in_ready, out_valid, cout, overflow, sum);
    end
    rst = 1'b0;
    #1 n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
    logic [W-1:0] tb [5] = '{16'h1111, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] s;
    logic co, ov;
    logic [W+1:0] e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], s, co, ov, lat);
      e = model(ta[i], tb[i], tc[i]);
      n_checks++;
      if ({ov, co, s} !== e) begin
        n_fail++;
        $display("FAIL arith_%0d: got ovf=%b co=%b sum=%h need ovf=%b co=%b sum=%h", i, ov, co, s, e[W+1], e[W], e[W-1:0]);
      end
      n_checks++;
      if (lat !== WORDS + 1) begin n_fail++; $display("FAIL latency_%0d: got %0d need %0d", i, lat, WORDS + 1); end
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL single_pulse_%0d: got out_valid=%b in_ready=%b need 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e1, e2;
    logic [W-1:0] s;
    logic co, ov;
    int t;
    bit bad;
    e1 = model(16'h1234, 16'h1111, 1'b0);
    e2 = model(16'h0F0F, 16'h0101, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 20);
    n_checks++;
    if ({overflow, cout, sum} !== e1 || !out_valid) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b ovf=%b co=%b sum=%h need ovf=%b co=%b sum=%h", out_valid, overflow, cout, sum, e1[W+1], e1[W], e1[W-1:0]);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({out_valid, in_ready, overflow, cout, sum} !== {2'b10, e1}) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL bp_hold: got v=%b rdy=%b sum=%h need held result with in_ready 0", out_valid, in_ready, sum); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 20);
    s = sum; co = cout; ov = overflow;
    n_checks++;
    if ({ov, co, s} !== e2 || t !== WORDS + 1) begin
      n_fail++;
      $display("FAIL bp_second: got ovf=%b co=%b sum=%h lat=%0d need ovf=%b co=%b sum=%h lat=%0d", ov, co, s, t, e2[W+1], e2[W], e2[W-1:0], WORDS + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, cout, overflow, sum} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got rdy=%b v=%b co=%b ovf=%b sum=%h need all 0", in_ready, out_valid, cout, overflow, sum);
    end
    rst = 1'b0;
    #1 n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_ready: got %b need 1", in_ready); end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL midrun_no_valid: got out_valid pulse, need none"); end
    run_op(16'h0003, 16'h0006, 1'b0, s, co, ov, lat);
    n_checks++;
    if ({ov, co, s} !== {2'b00, 16'h0009}) begin
      n_fail++;
      $display("FAIL midrun_next: got ovf=%b co=%b sum=%h need 0 0 0009", ov, co, s);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    localparam int N = 1000;
    logic [W+1:0] q[$];
    int got;
    got = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [W-1:0] xa, xb;
          logic xc;
          int t;
          xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
          @(negedge clk);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = xa; b = xb; cin = xc; in_valid = 1'b1;
          t = 0;
          while (!in_ready && t < 100) begin @(negedge clk); t++; end
          if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL rand_accept_timeout: op %0d never accepted", i);
            break;
          end
          q.push_back(model(xa, xb, xc));
          @(posedge clk);
          #1 in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < N && cyc < 50000) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom);
          if (out_valid && out_ready) begin
            logic [W+1:0] e;
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL rand_extra: got sum=%h with no operation outstanding", sum);
            end else begin
              e = q.pop_front();
              if ({overflow, cout, sum} !== e) begin
                n_fail++;
                $display("FAIL rand_%0d: got ovf=%b co=%b sum=%h need ovf=%b co=%b sum=%h", got, overflow, cout, sum, e[W+1], e[W], e[W-1:0]);
              end
            end
            got++;
          end
        end
        n_checks++;
        if (got != N) begin n_fail++; $display("FAIL rand_count: got %0d results need %0d", got, N); end
      end
    join
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-word adder that adds two `4*WORDS`-bit operands one 4-bit nibble per clock, least significant nibble first, through a single instance of the team's 4-bit ripple-carry adder `RCA`. It sits directly upstream of `RCA`: it registers operands, sequences nibbles into it, and holds the inter-nibble carry in a flop. It also collects `RCA`'s sum and per-stage carry outputs into a full-width result with carry-out and signed overflow. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- `WORDS`, default 4: number of nibbles per operand. Operand width is `4*WORDS`. Legal range is 2–16.

Ports:
- `clk`, input, 1: sole clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operand set `a`, `b`, `cin` is valid.
- `in_ready`, output, 1: block can accept operands. Combinational: `state==IDLE && !rst`.
- `a`, input, `4*WORDS`: operand A, unsigned or two's complement.
- `b`, input, `4*WORDS`: operand B.
- `cin`, input, 1: carry-in to nibble 0.
- `out_valid`, output, 1: result is valid. Registered.
- `out_ready`, input, 1: downstream accepts the result.
- `sum`, output, `4*WORDS`: `(a+b+cin) mod 2^(4*WORDS)`.
- `cout`, output, 1: carry out of the MSB nibble.
- `overflow`, output, 1: signed overflow. Equals `RCA` `carry[2] ^ carry[3]` on the last nibble.

## Operation
- The FSM has three states: `IDLE`, `RUN`, `DONE`.
- `IDLE`:
  - `in_ready=1`.
  - On `in_valid && in_ready`, capture `a`, `b` into shift registers and `cin` into the carry flop.
  - Clear nibble index `idx` to 0 and go to `RUN`.
  - When `in_valid=0`, stay in `IDLE`.
- `RUN`:
  - Each cycle, `RCA` sees nibble `idx` of A and B (low nibble of the shift registers) plus the carry flop.
  - Write `RCA.sum` into nibble `idx` of the result register.
  - Update the carry flop with `RCA.carry[3]`.
  - Shift the operand registers right by 4 and increment `idx`.
  - When `idx==WORDS-1`:
    - Latch `cout <= carry[3]` and `overflow <= carry[2]^carry[3]`.
    - Set `out_valid <= 1` and go to `DONE`.
  - Inputs are ignored in `RUN`; `in_ready=0`.
- `DONE`:
  - `sum`, `cout`, `overflow` and `out_valid` hold stable until `out_ready=1`.
  - On `out_valid && out_ready`, set `out_valid <= 0` and go to `IDLE`.
  - `in_ready=0` throughout `DONE`, so there is no overlap of a new capture with an unconsumed result.
- Arithmetic:
  - Pure modulo-`2^(4*WORDS)` add.
  - The `cout`/`overflow` definitions cover both unsigned and two's-complement interpretations.
  - The result is independent of `in_valid`/`out_ready` timing.
- Reset state (also applied when `rst` is asserted mid-operation, in any state):
  - `state=IDLE`, `idx=0`, carry flop 0, operand registers 0.
  - `sum=0`, `cout=0`, `overflow=0`, `out_valid=0`.
  - Any in-flight operation is discarded, with no partial result and no `out_valid` pulse.
  - `in_ready=0` while `rst=1`, and 1 on the first cycle after `rst` deasserts.

## Timing
- Capture at edge T0.
  - `RUN` occupies cycles T0+1 … T0+WORDS.
  - `out_valid` is 1 from cycle T0+WORDS+1.
  - Latency from accept to `out_valid` is `WORDS+1` cycles, 5 for `WORDS=4`.
- With `out_ready` held high:
  - `out_valid` is high for exactly 1 cycle.
  - `in_ready` rises the next cycle.
  - Peak throughput is one operation per `WORDS+2` cycles.
- `in_valid` asserted during `RUN`/`DONE` is not consumed. The upstream source must hold it; no data is lost or duplicated.
- Operand data is only sampled on the accept edge. Changes to `a`, `b`, `cin` after that have no effect.

## Structure
- Shared package `adder_pkg` holds:
  - `NIBBLE_W = 4`.
  - The `state_t` enum (`IDLE`, `RUN`, `DONE`).
  - The `idx` width function `$clog2(WORDS)`.
- There is exactly one sub-module: the existing `RCA` (ports `a[3:0]`, `b[3:0]`, `cin`, `sum[3:0]`, `carry[3:0]`), instantiated once and used purely combinationally.
- No other logic is duplicated per nibble.

## Test plan
All cases use `WORDS=4`.
- Add no carry: `a=0x1234`, `b=0x1111`, `cin=0` -> `sum=0x2345`, `cout=0`, `overflow=0`, `out_valid` exactly 5 cycles after accept.
- Full carry ripple across nibbles: `0xFFFF + 0x0001`, `cin=0` -> `sum=0x0000`, `cout=1`, `overflow=0`. Also `0x0000 + 0x0000`, `cin=1` -> `sum=0x0001`.
- Signed overflow:
  - `0x7FFF + 0x0001` -> `sum=0x8000`, `cout=0`, `overflow=1`.
  - `0x8000 + 0x8000` -> `sum=0x0000`, `cout=1`, `overflow=1`.
- Backpressure:
  - Hold `out_ready=0` for 4 cycles after `out_valid` -> `sum`, `cout`, `overflow` stable and `in_ready=0` throughout.
  - A second `in_valid` held meanwhile is accepted only on the cycle after the handshake, and produces its own correct result.
- Reset mid-`RUN`: assert `rst` for 1 cycle on the 2nd `RUN` cycle of `0x1234 + 0x1111` -> `out_valid` never rises for that operation, all outputs 0, `in_ready=1` the cycle after `rst` falls. A following `0x0003 + 0x0006` yields `sum=0x0009`.
- Random back-to-back: 1000 random `a`, `b`, `cin` with random `in_valid`/`out_ready` gaps -> every result matches the reference model, in order, with none dropped or duplicated.
